// File: rtl/apb_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : apb_req_arbiter
// Description : Round-robin arbiter that shares one APB master command port
//               between NUM_REQ requesters. It latches the winner's command,
//               holds it until the master reports ready, returns read data
//               with a per-requester done pulse, and aborts stalled
//               transfers with a watchdog.
// Revision    : 1.0 - initial release
// ============================================================================
module apb_req_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic                      pclk,
    input  logic                      preset_n,
    input  logic [NUM_REQ-1:0]        req_i,
    input  logic [NUM_REQ-1:0]        wr_i,
    input  logic [NUM_REQ*DATA_W-1:0] wdata_i,
    output logic [NUM_REQ-1:0]        gnt_o,
    output logic [NUM_REQ-1:0]        done_o,
    output logic                      err_o,
    output logic [DATA_W-1:0]         rdata_o,
    output logic [1:0]                add_o,
    output logic [DATA_W-1:0]         wdata_o,
    input  logic                      ready_i,
    input  logic [DATA_W-1:0]         rdata_i
);

    localparam int c_IDX_W = $clog2(NUM_REQ);
    localparam int c_WD_W  = $clog2(TIMEOUT) + 1;

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_BUSY = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    localparam logic [1:0] c_CMD_IDLE  = 2'b00;
    localparam logic [1:0] c_CMD_READ  = 2'b01;
    localparam logic [1:0] c_CMD_WRITE = 2'b11;

    localparam logic [c_WD_W-1:0]  c_WD_LAST  = c_WD_W'(TIMEOUT - 1);
    localparam logic [c_IDX_W:0]   c_NUM      = (c_IDX_W + 1)'(NUM_REQ);
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(NUM_REQ - 1);

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [c_IDX_W-1:0] r_ptr;
    logic [c_IDX_W-1:0] r_idx;
    logic [c_WD_W-1:0]  r_wd;

    logic [NUM_REQ-1:0] w_rot;
    logic [c_IDX_W-1:0] w_off;
    logic               w_found;
    logic [c_IDX_W:0]   w_sum;
    logic [c_IDX_W-1:0] w_win;
    logic [NUM_REQ-1:0] w_win_oh;
    logic               w_win_wr;
    logic [DATA_W-1:0]  w_wdata_sel;
    logic               w_exit;
    logic               w_timeout;

    // Rotate requests so bit 0 is the pointer position, take the lowest set
    // bit, then map the offset back to an absolute index modulo NUM_REQ.
    always_comb begin
        w_rot   = NUM_REQ'({req_i, req_i} >> r_ptr);
        w_off   = '0;
        w_found = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!w_found && w_rot[i]) begin
                w_found = 1'b1;
                w_off   = c_IDX_W'(i);
            end
        end
        w_sum = {1'b0, r_ptr} + {1'b0, w_off};
        if (w_sum >= c_NUM) begin
            w_sum = w_sum - c_NUM;
        end
        w_win    = w_sum[c_IDX_W-1:0];
        w_win_oh = NUM_REQ'(1) << w_win;
        w_win_wr = wr_i[w_win];
    end

    // Pick the winner's write-data slice with constant part-selects.
    always_comb begin
        w_wdata_sel = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_win == c_IDX_W'(i)) begin
                w_wdata_sel = wdata_i[i*DATA_W +: DATA_W];
            end
        end
    end

    // Transfer ends on ready or when the watchdog reaches its last count.
    always_comb begin
        w_timeout = (r_wd == c_WD_LAST);
        w_exit    = ready_i || w_timeout;
    end

    // State register.
    always_ff @(posedge pclk) begin
        if (!preset_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: IDLE -> BUSY on any request, BUSY -> DONE on exit,
    // DONE always returns to IDLE after one cycle.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:  if (|req_i) w_state_nxt = c_BUSY;
            c_BUSY:  if (w_exit) w_state_nxt = c_DONE;
            c_DONE:  w_state_nxt = c_IDLE;
            default: w_state_nxt = c_IDLE;
        endcase
    end

    // Datapath: latch command at grant, capture completion, advance pointer.
    always_ff @(posedge pclk) begin
        if (!preset_n) begin
            r_ptr   <= '0;
            r_idx   <= '0;
            r_wd    <= '0;
            gnt_o   <= '0;
            done_o  <= '0;
            err_o   <= 1'b0;
            rdata_o <= '0;
            add_o   <= c_CMD_IDLE;
            wdata_o <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (|req_i) begin
                        r_idx   <= w_win;
                        gnt_o   <= w_win_oh;
                        add_o   <= w_win_wr ? c_CMD_WRITE : c_CMD_READ;
                        wdata_o <= w_wdata_sel;
                        r_wd    <= '0;
                    end
                end
                c_BUSY: begin
                    if (w_exit) begin
                        add_o  <= c_CMD_IDLE;
                        done_o <= gnt_o;
                        // A real ready wins over a simultaneous timeout.
                        err_o  <= !ready_i;
                        if (ready_i && (add_o == c_CMD_READ)) begin
                            rdata_o <= rdata_i;
                        end
                    end else begin
                        r_wd <= r_wd + c_WD_W'(1);
                    end
                end
                c_DONE: begin
                    done_o <= '0;
                    err_o  <= 1'b0;
                    gnt_o  <= '0;
                    r_ptr  <= (r_idx == c_LAST_IDX) ? '0 : r_idx + c_IDX_W'(1);
                end
                default: begin
                    gnt_o  <= '0;
                    done_o <= '0;
                    err_o  <= 1'b0;
                    add_o  <= c_CMD_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_apb_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_apb_req_arbiter
// Description : Directed self-checking bench for apb_req_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_apb_req_arbiter;

    localparam int NUM_REQ = 4;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 16;

    logic                      pclk;
    logic                      preset_n;
    logic [NUM_REQ-1:0]        req_i;
    logic [NUM_REQ-1:0]        wr_i;
    logic [NUM_REQ*DATA_W-1:0] wdata_i;
    logic [NUM_REQ-1:0]        gnt_o;
    logic [NUM_REQ-1:0]        done_o;
    logic                      err_o;
    logic [DATA_W-1:0]         rdata_o;
    logic [1:0]                add_o;
    logic [DATA_W-1:0]         wdata_o;
    logic                      ready_i;
    logic [DATA_W-1:0]         rdata_i;

    int n_tests = 0;
    int n_fail  = 0;

    apb_req_arbiter #(
        .NUM_REQ(NUM_REQ),
        .DATA_W (DATA_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .pclk    (pclk),
        .preset_n(preset_n),
        .req_i   (req_i),
        .wr_i    (wr_i),
        .wdata_i (wdata_i),
        .gnt_o   (gnt_o),
        .done_o  (done_o),
        .err_o   (err_o),
        .rdata_o (rdata_o),
        .add_o   (add_o),
        .wdata_o (wdata_o),
        .ready_i (ready_i),
        .rdata_i (rdata_i)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    // Advance one rising edge and settle before sampling.
    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic test_reset();
        preset_n = 1'b0;
        req_i    = '0;
        wr_i     = '0;
        wdata_i  = '0;
        ready_i  = 1'b0;
        rdata_i  = '0;
        tick();
        tick();
        n_tests++;
        if ({gnt_o, done_o, err_o, add_o} !== 11'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl got gnt=%b done=%b err=%b add=%b exp all 0", gnt_o, done_o, err_o, add_o);
        end
        n_tests++;
        if ({wdata_o, rdata_o} !== 64'h0) begin
            n_fail++;
            $display("FAIL reset_data got wdata=%h rdata=%h exp 0", wdata_o, rdata_o);
        end
        preset_n = 1'b1;
    endtask

    task automatic test_single_write();
        req_i = 4'b0001;
        wr_i  = 4'b0001;
        wdata_i[0*DATA_W +: DATA_W] = 32'h1234abcd;
        tick();
        n_tests++;
        if (gnt_o !== 4'b0001 || add_o !== 2'b11 || wdata_o !== 32'h1234abcd) begin
            n_fail++;
            $display("FAIL wr_grant got gnt=%b add=%b wdata=%h exp 0001 11 1234abcd", gnt_o, add_o, wdata_o);
        end
        tick();
        tick();
        n_tests++;
        if (add_o !== 2'b11 || wdata_o !== 32'h1234abcd || done_o !== 4'b0000) begin
            n_fail++;
            $display("FAIL wr_hold got add=%b wdata=%h done=%b exp 11 1234abcd 0000", add_o, wdata_o, done_o);
        end
        ready_i = 1'b1;
        tick();
        n_tests++;
        if (done_o !== 4'b0001 || err_o !== 1'b0 || add_o !== 2'b00) begin
            n_fail++;
            $display("FAIL wr_done got done=%b err=%b add=%b exp 0001 0 00", done_o, err_o, add_o);
        end
        ready_i = 1'b0;
        req_i   = '0;
        tick();
        n_tests++;
        if (done_o !== 4'b0000 || gnt_o !== 4'b0000 || add_o !== 2'b00) begin
            n_fail++;
            $display("FAIL wr_after got done=%b gnt=%b add=%b exp 0000 0000 00", done_o, gnt_o, add_o);
        end
    endtask

    task automatic test_single_read();
        req_i = 4'b0100;
        wr_i  = 4'b0000;
        tick();
        n_tests++;
        if (gnt_o !== 4'b0100 || add_o !== 2'b01) begin
            n_fail++;
            $display("FAIL rd_grant got gnt=%b add=%b exp 0100 01", gnt_o, add_o);
        end
        ready_i = 1'b1;
        rdata_i = 32'h5678ef01;
        tick();
        n_tests++;
        if (done_o !== 4'b0100 || err_o !== 1'b0 || rdata_o !== 32'h5678ef01) begin
            n_fail++;
            $display("FAIL rd_done got done=%b err=%b rdata=%h exp 0100 0 5678ef01", done_o, err_o, rdata_o);
        end
        ready_i = 1'b0;
        rdata_i = '0;
        req_i   = '0;
        tick();
        n_tests++;
        if (rdata_o !== 32'h5678ef01 || done_o !== 4'b0000) begin
            n_fail++;
            $display("FAIL rd_hold got rdata=%h done=%b exp 5678ef01 0000", rdata_o, done_o);
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_oh;
        int         order [5] = '{0, 1, 2, 3, 0};
        preset_n = 1'b0;
        tick();
        preset_n = 1'b1;
        req_i = 4'b1111;
        wr_i  = 4'b1010;
        for (int n = 0; n < 5; n++) begin
            exp_oh = 4'b0001 << order[n];
            tick();
            n_tests++;
            if (gnt_o !== exp_oh || add_o !== ((wr_i[order[n]]) ? 2'b11 : 2'b01)) begin
                n_fail++;
                $display("FAIL rr_grant%0d got gnt=%b add=%b exp gnt=%b", n, gnt_o, add_o, exp_oh);
            end
            ready_i = 1'b1;
            rdata_i = 32'ha0000000 + order[n];
            tick();
            n_tests++;
            if (done_o !== exp_oh || add_o !== 2'b00) begin
                n_fail++;
                $display("FAIL rr_done%0d got done=%b add=%b exp %b 00", n, done_o, add_o, exp_oh);
            end
            ready_i = 1'b0;
            if (n == 4) req_i = '0;
            tick();
            n_tests++;
            if (add_o !== 2'b00 || gnt_o !== 4'b0000) begin
                n_fail++;
                $display("FAIL rr_gap%0d got add=%b gnt=%b exp 00 0000", n, add_o, gnt_o);
            end
        end
    endtask

    task automatic test_timeout();
        int early = 0;
        req_i   = 4'b0110;
        wr_i    = 4'b0000;
        rdata_i = 32'hdeadbeef;
        tick();
        n_tests++;
        if (gnt_o !== 4'b0010 || add_o !== 2'b01) begin
            n_fail++;
            $display("FAIL to_grant got gnt=%b add=%b exp 0010 01", gnt_o, add_o);
        end
        for (int c = 1; c < TIMEOUT; c++) begin
            tick();
            if (done_o !== 4'b0000) early++;
        end
        n_tests++;
        if (early != 0) begin
            n_fail++;
            $display("FAIL to_early got %0d early done cycles exp 0", early);
        end
        tick();
        n_tests++;
        if (done_o !== 4'b0010 || err_o !== 1'b1 || add_o !== 2'b00 || rdata_o !== 32'ha0000000) begin
            n_fail++;
            $display("FAIL to_abort got done=%b err=%b add=%b rdata=%h exp 0010 1 00 a0000000", done_o, err_o, add_o, rdata_o);
        end
        req_i = 4'b0100;
        tick();
        n_tests++;
        if (done_o !== 4'b0000 || err_o !== 1'b0 || gnt_o !== 4'b0000) begin
            n_fail++;
            $display("FAIL to_clear got done=%b err=%b gnt=%b exp 0000 0 0000", done_o, err_o, gnt_o);
        end
        tick();
        n_tests++;
        if (gnt_o !== 4'b0100) begin
            n_fail++;
            $display("FAIL to_next got gnt=%b exp 0100", gnt_o);
        end
        ready_i = 1'b1;
        rdata_i = 32'hcafe0002;
        tick();
        n_tests++;
        if (done_o !== 4'b0100 || err_o !== 1'b0 || rdata_o !== 32'hcafe0002) begin
            n_fail++;
            $display("FAIL to_next_done got done=%b err=%b rdata=%h exp 0100 0 cafe0002", done_o, err_o, rdata_o);
        end
        ready_i = 1'b0;
        req_i   = '0;
        tick();
    endtask

    task automatic test_reset_mid_busy();
        req_i = 4'b0001;
        wr_i  = 4'b0001;
        wdata_i[0*DATA_W +: DATA_W] = 32'h11111111;
        tick();
        n_tests++;
        if (gnt_o !== 4'b0001 || add_o !== 2'b11) begin
            n_fail++;
            $display("FAIL rst_busy_grant got gnt=%b add=%b exp 0001 11", gnt_o, add_o);
        end
        tick();
        preset_n = 1'b0;
        req_i    = 4'b1010;
        wr_i     = 4'b0000;
        tick();
        n_tests++;
        if ({gnt_o, done_o, err_o, add_o} !== 11'b0 || wdata_o !== 32'h0 || rdata_o !== 32'h0) begin
            n_fail++;
            $display("FAIL rst_busy_clear got gnt=%b done=%b err=%b add=%b wdata=%h rdata=%h exp all 0",
                     gnt_o, done_o, err_o, add_o, wdata_o, rdata_o);
        end
        preset_n = 1'b1;
        tick();
        n_tests++;
        if (gnt_o !== 4'b0010 || add_o !== 2'b01) begin
            n_fail++;
            $display("FAIL rst_busy_regrant got gnt=%b add=%b exp 0010 01", gnt_o, add_o);
        end
        ready_i = 1'b1;
        tick();
        ready_i = 1'b0;
        req_i   = '0;
        tick();
    endtask

    task automatic test_data_stability();
        ready_i = 1'b1;
        tick();
        n_tests++;
        if (done_o !== 4'b0000 || add_o !== 2'b00) begin
            n_fail++;
            $display("FAIL idle_ready got done=%b add=%b exp 0000 00", done_o, add_o);
        end
        ready_i = 1'b0;
        req_i   = 4'b0100;
        wr_i    = 4'b0100;
        wdata_i[2*DATA_W +: DATA_W] = 32'haaaa5555;
        tick();
        n_tests++;
        if (gnt_o !== 4'b0100 || add_o !== 2'b11 || wdata_o !== 32'haaaa5555) begin
            n_fail++;
            $display("FAIL stab_grant got gnt=%b add=%b wdata=%h exp 0100 11 aaaa5555", gnt_o, add_o, wdata_o);
        end
        wdata_i[2*DATA_W +: DATA_W] = 32'h0;
        req_i = 4'b0000;
        wr_i  = 4'b0000;
        tick();
        n_tests++;
        if (gnt_o !== 4'b0100 || add_o !== 2'b11 || wdata_o !== 32'haaaa5555) begin
            n_fail++;
            $display("FAIL stab_hold got gnt=%b add=%b wdata=%h exp 0100 11 aaaa5555", gnt_o, add_o, wdata_o);
        end
        ready_i = 1'b1;
        tick();
        n_tests++;
        if (done_o !== 4'b0100 || err_o !== 1'b0) begin
            n_fail++;
            $display("FAIL stab_done got done=%b err=%b exp 0100 0", done_o, err_o);
        end
        ready_i = 1'b0;
        tick();
        n_tests++;
        if (done_o !== 4'b0000 || gnt_o !== 4'b0000) begin
            n_fail++;
            $display("FAIL stab_after got done=%b gnt=%b exp 0000 0000", done_o, gnt_o);
        end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_single_read();
        test_round_robin();
        test_timeout();
        test_reset_mid_busy();
        test_data_stability();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got no finish exp finish before 200000");
        $fatal(1, "simulation time limit exceeded");
    end

endmodule
`default_nettype wire

// File: doc/apb_req_arbiter.md
# apb_req_arbiter

Round-robin arbiter and sequencer that shares the single APB master/slave datapath (apb_master_slave_top) between NUM_REQ independent requesters. It grants one requester at a time and drives the master's command inputs (add/wdata). It holds the command until the master reports ready, returns read data with a per-requester done pulse, and aborts stalled transfers with a watchdog. It sits between requester logic and the add_i/external_wdata_i/ready_o/rdata_o pins of the APB top.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- DATA_W, 32, data width; must match APB datapath width
- TIMEOUT, 16, max cycles in BUSY waiting for ready before abort (>=2)
- pclk  in  1  clock; all logic on rising edge
- preset_n  in  1  reset; synchronous, active-low
- req_i  in  NUM_REQ  per-requester request; held high until its done_o
- wr_i  in  NUM_REQ  per-requester direction: 1 write, 0 read
- wdata_i  in  NUM_REQ*DATA_W  per-requester write data, slice k = bits [k*DATA_W +: DATA_W]
- gnt_o  out  NUM_REQ  one-hot grant, high from grant cycle through DONE
- done_o  out  NUM_REQ  one-cycle completion pulse to granted requester
- err_o  out  1  valid with done_o; 1 = transfer aborted by watchdog
- rdata_o  out  DATA_W  captured read data, valid with done_o on reads
- add_o  out  2  command to APB master: 2'b00 idle, 2'b01 read, 2'b11 write
- wdata_o  out  DATA_W  write data to APB master
- ready_i  in  1  ready from APB master (transfer complete)
- rdata_i  in  DATA_W  read data from APB master

## Operation
- States: IDLE, BUSY, DONE. Reset state IDLE.
- IDLE:
  - On any req_i bit high, select winner = first set bit searching ptr, ptr+1, …, wrapping modulo NUM_REQ.
  - Register idx, set gnt_o[idx], add_o <= wr_i[idx] ? 2'b11 : 2'b01, wdata_o <= wdata_i slice idx (latched; later changes ignored), clear watchdog, go BUSY.
- BUSY:
  - add_o held constant.
  - ready_i sampled high: add_o <= 2'b00; done_o[idx] <= 1; err_o <= 0; rdata_o <= rdata_i if read (unchanged on write); go DONE.
  - Else, if watchdog == TIMEOUT-1: same exit but err_o <= 1, rdata_o unchanged.
  - Else watchdog increments.
- DONE:
  - One cycle. done_o and err_o cleared, gnt_o cleared, ptr <= (idx+1) mod NUM_REQ, go IDLE.
  - This guaranteed add_o=00 cycle lets the master return to idle before the next command.
- ptr changes only in DONE, so a requester that just completed gets lowest priority next round.
- req_i deasserted during BUSY is ignored: the transfer completes and done_o still pulses.
- req_i bits outside the grant are ignored until IDLE.
- Watchdog width: $clog2(TIMEOUT)+1 bits; never wraps.

## Timing
- Reset (preset_n low at a rising edge): state IDLE, ptr 0, gnt_o 0, done_o 0, err_o 0, add_o 2'b00, wdata_o 0, rdata_o 0, watchdog 0.
  - Reset mid-transfer aborts it with no done_o.
- Grant latency: req_i seen at edge N -> gnt_o/add_o valid after edge N.
- Completion: ready_i high at edge M -> done_o/rdata_o valid after M for exactly one cycle; add_o is 00 after M.
- Per-transfer occupancy: 1 (IDLE) + k (BUSY, k = cycles until ready) + 1 (DONE).
  - Back-to-back requests: next grant at the edge after DONE.
- Timeout: if ready_i is never high, done_o with err_o=1 is asserted after the TIMEOUT-th BUSY edge.
- ready_i high in IDLE or DONE is ignored.

## Test plan
- Single write: reset, req_i=4'b0001, wr_i[0]=1, wdata slice0=32'h1234abcd, ready after 3 cycles -> add_o=11, wdata_o=32'h1234abcd until ready; done_o=0001 one cycle, err_o=0, then add_o=00 for one cycle.
- Single read: req_i[2], wr_i[2]=0, rdata_i=32'h5678ef01 at ready -> add_o=01, done_o=0100, rdata_o=32'h5678ef01.
- Round-robin: req_i=4'b1111 held, ready 1 cycle after each command -> grant order 0,1,2,3,0; each gap shows one add_o=00 cycle.
- Timeout: TIMEOUT=16, ready_i tied 0 -> done_o pulse with err_o=1 exactly 16 BUSY cycles after the grant; next requester is then granted normally.
- Reset mid-BUSY: assert preset_n=0 during BUSY -> next edge gives all outputs 0, no done_o, ptr=0; the following request is granted to the lowest set index.
- Data stability: change wdata_i slice and req_i during BUSY -> wdata_o and add_o unchanged, done_o still pulses.
